// File: rtl/mem_backup_ram.sv
// Block-RAM backing store for the memory-backup deserializer's wide port.
// Line-granular read/write commands; writes take BEATS data beats, reads
// stream BEATS tagged beats back through a registered RAM read.
module mem_backup_ram #(
  parameter int DATA_BITS = 128,
  parameter int ADDR_BITS = 26,
  parameter int TAG_BITS  = 5,
  parameter int LINE_BITS = 12,
  parameter int BEATS     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_req_valid,
  output logic                 mem_req_ready,
  input  logic                 mem_req_rw,
  input  logic [ADDR_BITS-1:0] mem_req_addr,
  input  logic [TAG_BITS-1:0]  mem_req_tag,
  input  logic                 mem_req_data_valid,
  output logic                 mem_req_data_ready,
  input  logic [DATA_BITS-1:0] mem_req_data_bits,
  output logic                 mem_resp_valid,
  output logic [DATA_BITS-1:0] mem_resp_data,
  output logic [TAG_BITS-1:0]  mem_resp_tag
);

  localparam int BEAT_W = $clog2(BEATS);
  localparam int IDX_W  = LINE_BITS + BEAT_W;
  localparam int WORDS  = 1 << IDX_W;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);
  localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [LINE_BITS-1:0]   line_q, line_d;
  logic [TAG_BITS-1:0]    tag_q, tag_d;
  logic [BEAT_W-1:0]      beat_q, beat_d;

  logic                   req_fire;
  logic                   data_fire;
  logic                   rd_issue;
  logic [IDX_W-1:0]       ram_idx;

  logic                   resp_valid_q;
  logic [DATA_BITS-1:0]   resp_data_q;
  logic [TAG_BITS-1:0]    resp_tag_q;

  // Storage; name is fixed because preload tooling targets it hierarchically.
  logic [DATA_BITS-1:0]   ram [0:WORDS-1];

  // Address bits above the stored line range are deliberately ignored so
  // accesses wrap modulo the array size.
  if (ADDR_BITS > LINE_BITS) begin : g_addr_hi
    logic addr_hi_unused;
    assign addr_hi_unused = ^mem_req_addr[ADDR_BITS-1:LINE_BITS];
  end

  assign req_fire  = mem_req_valid && mem_req_ready;
  assign data_fire = mem_req_data_valid && mem_req_data_ready;
  assign rd_issue  = (state_q == S_READ) && !reset;
  assign ram_idx   = {line_q, beat_q};

  // State register: synchronous reset back to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: a write line ends on its last accepted beat, a read line
  // ends after issuing its last beat (reads never stall).
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_fire) begin
          state_d = mem_req_rw ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        if (data_fire && (beat_q == BEAT_LAST)) begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        if (beat_q == BEAT_LAST) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs, forced low while reset is asserted.
  always_comb begin
    mem_req_ready      = 1'b0;
    mem_req_data_ready = 1'b0;
    if (!reset) begin
      case (state_q)
        S_IDLE:  mem_req_ready      = 1'b1;
        S_WRITE: mem_req_data_ready = 1'b1;
        default: ;
      endcase
    end
  end

  // Command latch and beat counter next-state; the counter wraps naturally
  // at the end of a line because it is exactly log2(BEATS) bits wide.
  always_comb begin
    line_d = line_q;
    tag_d  = tag_q;
    beat_d = beat_q;
    if (req_fire) begin
      line_d = mem_req_addr[LINE_BITS-1:0];
      tag_d  = mem_req_tag;
      beat_d = '0;
    end else if (data_fire || rd_issue) begin
      beat_d = beat_q + BEAT_ONE;
    end
  end

  // Command latch and beat counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      line_q <= '0;
      tag_q  <= '0;
      beat_q <= '0;
    end else begin
      line_q <= line_d;
      tag_q  <= tag_d;
      beat_q <= beat_d;
    end
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (data_fire) begin
      ram[ram_idx] <= mem_req_data_bits;
    end
  end

  // Registered read: a beat issued this cycle is presented next cycle,
  // independent of the FSM so the last beat can overlap a new accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_tag_q   <= '0;
    end else begin
      resp_valid_q <= rd_issue;
      if (rd_issue) begin
        resp_data_q <= ram[ram_idx];
        resp_tag_q  <= tag_q;
      end
    end
  end

  assign mem_resp_valid = resp_valid_q;
  assign mem_resp_data  = resp_data_q;
  assign mem_resp_tag   = resp_tag_q;

endmodule
